// File: rtl/pifo_reg_array_pkg.sv
// Shared definitions for the register-based PIFO storage stage and its max-tree consumers.
package pifo_reg_array_pkg;

  localparam int unsigned DefRegWidth  = 4;
  localparam int unsigned DefIdxWidth  = 2;
  localparam int unsigned DefDataWidth = 8;

  // LSB position of slot i inside a flattened bus whose per-slot field is w bits wide.
  function automatic int unsigned slot_lsb(input int unsigned i, input int unsigned w);
    return i * w;
  endfunction

endpackage

// File: rtl/pifo_reg_array_if.sv
// Insert and remove handshakes between the PIFO control/max-tree side and the slot array.
interface pifo_reg_array_if
  import pifo_reg_array_pkg::*;
#(
  parameter int unsigned IDX_WIDTH  = DefIdxWidth,
  parameter int unsigned DATA_WIDTH = DefDataWidth
);

  logic                  ins_valid;
  logic                  ins_ready;
  logic [DATA_WIDTH-1:0] ins_data;
  logic                  rm_req;
  logic [IDX_WIDTH-1:0]  rm_idx;
  logic                  rm_valid;
  logic [DATA_WIDTH-1:0] rm_data;
  logic                  rm_err;

  modport master (
    output ins_valid, ins_data, rm_req, rm_idx,
    input  ins_ready, rm_valid, rm_data, rm_err
  );

  modport slave (
    input  ins_valid, ins_data, rm_req, rm_idx,
    output ins_ready, rm_valid, rm_data, rm_err
  );

endinterface

// File: rtl/pifo_free_slot_enc.sv
// Lowest-zero priority encoder: picks the lowest-numbered empty slot.
module pifo_free_slot_enc
  import pifo_reg_array_pkg::*;
#(
  parameter int unsigned REG_WIDTH = DefRegWidth,
  parameter int unsigned IDX_WIDTH = DefIdxWidth
) (
  input  logic [REG_WIDTH-1:0] vld,
  output logic [IDX_WIDTH-1:0] free_idx,
  output logic                 any_free
);

  // Scan from the top down so the lowest empty slot wins.
  always_comb begin
    free_idx = '0;
    any_free = 1'b0;
    for (int i = REG_WIDTH - 1; i >= 0; i--) begin
      if (!vld[i]) begin
        any_free = 1'b1;
        free_idx = IDX_WIDTH'(i);
      end
    end
  end

endmodule

// File: rtl/pifo_reg_array.sv
// PIFO storage stage: slot registers with valid bits, indexed removal, flattened max-tree feed.
module pifo_reg_array
  import pifo_reg_array_pkg::*;
#(
  parameter int unsigned REG_WIDTH  = DefRegWidth,
  parameter int unsigned IDX_WIDTH  = DefIdxWidth,
  parameter int unsigned DATA_WIDTH = DefDataWidth
) (
  input  logic                            axis_aclk,
  input  logic                            axis_resetn,
  pifo_reg_array_if.slave                 bus,
  output logic [REG_WIDTH*DATA_WIDTH-1:0] data_out,
  output logic [REG_WIDTH*IDX_WIDTH-1:0]  idx_out,
  output logic [REG_WIDTH-1:0]            vld_out,
  output logic [IDX_WIDTH:0]              count,
  output logic                            full,
  output logic                            empty
);

  logic [1:0]            rst_sync_q;
  logic                  rst_int_n;

  logic [DATA_WIDTH-1:0] slot_q [REG_WIDTH];
  logic [DATA_WIDTH-1:0] slot_d [REG_WIDTH];
  logic [REG_WIDTH-1:0]  vld_q, vld_d;
  logic [IDX_WIDTH:0]    count_q, count_d;
  logic                  rm_valid_q, rm_err_q;
  logic [DATA_WIDTH-1:0] rm_data_q, rm_data_d;

  logic [IDX_WIDTH-1:0]  free_idx;
  logic                  any_free;
  logic                  rm_hit;
  logic [DATA_WIDTH-1:0] rm_sel;
  logic                  ins_fire, rm_fire;

  // Reset synchronizer: assertion reaches the state immediately, release waits two edges.
  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) rst_sync_q <= '0;
    else              rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_int_n = rst_sync_q[1];

  pifo_free_slot_enc #(
    .REG_WIDTH (REG_WIDTH),
    .IDX_WIDTH (IDX_WIDTH)
  ) u_free_slot_enc (
    .vld      (vld_q),
    .free_idx (free_idx),
    .any_free (any_free)
  );

  // Look up the remove target; indices past REG_WIDTH never match, so they miss.
  always_comb begin
    rm_hit = 1'b0;
    rm_sel = '0;
    for (int i = 0; i < REG_WIDTH; i++) begin
      if (bus.rm_idx == IDX_WIDTH'(i) && vld_q[i]) begin
        rm_hit = 1'b1;
        rm_sel = slot_q[i];
      end
    end
  end

  assign ins_fire = bus.ins_valid & any_free;
  assign rm_fire  = bus.rm_req & rm_hit;

  // Next state; free slot comes from the pre-remove vector so it never aliases the removed slot.
  always_comb begin
    vld_d     = vld_q;
    slot_d    = slot_q;
    count_d   = count_q;
    rm_data_d = rm_data_q;
    if (rm_fire) begin
      for (int i = 0; i < REG_WIDTH; i++) begin
        if (bus.rm_idx == IDX_WIDTH'(i)) vld_d[i] = 1'b0;
      end
      rm_data_d = rm_sel;
    end
    if (ins_fire) begin
      vld_d[free_idx]  = 1'b1;
      slot_d[free_idx] = bus.ins_data;
    end
    if (ins_fire && !rm_fire) count_d = count_q + {{IDX_WIDTH{1'b0}}, 1'b1};
    else if (!ins_fire && rm_fire) count_d = count_q - {{IDX_WIDTH{1'b0}}, 1'b1};
  end

  // State registers; slot data is left stale on remove and gated by vld downstream.
  always_ff @(posedge axis_aclk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      slot_q     <= '{default: '0};
      vld_q      <= '0;
      count_q    <= '0;
      rm_valid_q <= 1'b0;
      rm_err_q   <= 1'b0;
      rm_data_q  <= '0;
    end else begin
      slot_q     <= slot_d;
      vld_q      <= vld_d;
      count_q    <= count_d;
      rm_valid_q <= rm_fire;
      rm_err_q   <= bus.rm_req & ~rm_hit;
      rm_data_q  <= rm_data_d;
    end
  end

  assign full          = &vld_q;
  assign empty         = ~|vld_q;
  assign bus.ins_ready = ~full;
  assign bus.rm_valid  = rm_valid_q;
  assign bus.rm_err    = rm_err_q;
  assign bus.rm_data   = rm_data_q;
  assign vld_out       = vld_q;
  assign count         = count_q;

  for (genvar i = 0; i < REG_WIDTH; i++) begin : g_flat
    assign data_out[slot_lsb(i, DATA_WIDTH) +: DATA_WIDTH] = slot_q[i];
    assign idx_out[slot_lsb(i, IDX_WIDTH) +: IDX_WIDTH]    = IDX_WIDTH'(i);
  end

endmodule

// File: tb/tb_pifo_reg_array.sv
// Self-checking bench for pifo_reg_array: directed scenarios plus random traffic vs a slot model.
module tb_pifo_reg_array;
  import pifo_reg_array_pkg::*;

  localparam int RW = 4;
  localparam int IW = 2;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  pifo_reg_array_if #(.IDX_WIDTH(IW), .DATA_WIDTH(DW)) bus ();

  logic [RW*DW-1:0] data_out;
  logic [RW*IW-1:0] idx_out;
  logic [RW-1:0]    vld_out;
  logic [IW:0]      count;
  logic             full, empty;

  pifo_reg_array #(.REG_WIDTH(RW), .IDX_WIDTH(IW), .DATA_WIDTH(DW)) dut (
    .axis_aclk   (clk),
    .axis_resetn (resetn),
    .bus         (bus),
    .data_out    (data_out),
    .idx_out     (idx_out),
    .vld_out     (vld_out),
    .count       (count),
    .full        (full),
    .empty       (empty)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: a plain array of slots with occupancy flags.
  logic [DW-1:0] m_data [RW];
  logic          m_vld  [RW];
  logic          m_rm_valid, m_rm_err;
  logic [DW-1:0] m_rm_data;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < RW; i++) begin
      m_data[i] = '0;
      m_vld[i]  = 1'b0;
    end
    m_rm_valid = 1'b0;
    m_rm_err   = 1'b0;
    m_rm_data  = '0;
  endtask

  function automatic int m_count();
    int n = 0;
    for (int i = 0; i < RW; i++) n += int'(m_vld[i]);
    return n;
  endfunction

  function automatic logic [RW-1:0] m_vld_vec();
    logic [RW-1:0] v;
    for (int i = 0; i < RW; i++) v[i] = m_vld[i];
    return v;
  endfunction

  task automatic check_all(input string tag);
    logic [RW*DW-1:0] ed;
    logic [RW*IW-1:0] ei;
    for (int i = 0; i < RW; i++) begin
      ed[i*DW +: DW] = m_data[i];
      ei[i*IW +: IW] = IW'(i);
    end
    check({tag, ".vld"}, 64'(vld_out), 64'(m_vld_vec()));
    check({tag, ".data"}, 64'(data_out), 64'(ed));
    check({tag, ".idx"}, 64'(idx_out), 64'(ei));
    check({tag, ".count"}, 64'(count), 64'(m_count()));
    check({tag, ".full"}, 64'(full), 64'(m_count() == RW));
    check({tag, ".empty"}, 64'(empty), 64'(m_count() == 0));
    check({tag, ".ins_ready"}, 64'(bus.ins_ready), 64'(m_count() != RW));
    check({tag, ".rm_valid"}, 64'(bus.rm_valid), 64'(m_rm_valid));
    check({tag, ".rm_err"}, 64'(bus.rm_err), 64'(m_rm_err));
    check({tag, ".rm_data"}, 64'(bus.rm_data), 64'(m_rm_data));
  endtask

  // One clock cycle: drive at negedge, advance the model, compare just after the edge.
  task automatic step(input string tag, input logic iv, input logic [DW-1:0] id,
                      input logic rr, input logic [IW-1:0] ri);
    bit ins_ok, rm_ok;
    int free;
    @(negedge clk);
    bus.ins_valid = iv;
    bus.ins_data  = id;
    bus.rm_req    = rr;
    bus.rm_idx    = ri;
    #1;
    check({tag, ".ready_pre"}, 64'(bus.ins_ready), 64'(m_count() != RW));
    free = -1;
    for (int i = RW - 1; i >= 0; i--) if (!m_vld[i]) free = i;
    ins_ok = iv && (free >= 0);
    rm_ok  = rr && (int'(ri) < RW) && m_vld[ri];
    m_rm_valid = rm_ok;
    m_rm_err   = rr && !rm_ok;
    if (rm_ok) begin
      m_rm_data  = m_data[ri];
      m_vld[ri]  = 1'b0;
    end
    if (ins_ok) begin
      m_data[free] = id;
      m_vld[free]  = 1'b1;
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    bus.ins_valid = 1'b0;
    bus.ins_data  = '0;
    bus.rm_req    = 1'b0;
    bus.rm_idx    = '0;
    model_reset();

    // Reset state
    #3;
    check_all("reset");
    @(negedge clk);
    resetn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_all("post_reset");

    // 1: three inserts
    step("t1_a", 1'b1, 8'h10, 1'b0, 2'd0);
    step("t1_b", 1'b1, 8'h30, 1'b0, 2'd0);
    step("t1_c", 1'b1, 8'h20, 1'b0, 2'd0);
    check("t1_vld", 64'(vld_out), 64'h7);
    check("t1_slots", 64'(data_out[23:0]), 64'h203010);
    check("t1_idx", 64'(idx_out), 64'hE4);

    // 2: fill, then hold 0x55 against a full array
    step("t2_fill", 1'b1, 8'h40, 1'b0, 2'd0);
    check("t2_full", 64'(full), 64'h1);
    step("t2_hold_a", 1'b1, 8'h55, 1'b0, 2'd0);
    step("t2_hold_b", 1'b1, 8'h55, 1'b0, 2'd0);
    check("t2_data", 64'(data_out), 64'h40203010);

    // 3: remove slot 1 while 0x55 is held; it lands in slot 1 afterwards
    step("t3_rm", 1'b1, 8'h55, 1'b1, 2'd1);
    check("t3_rm_data", 64'(bus.rm_data), 64'h30);
    check("t3_vld", 64'(vld_out), 64'hD);
    step("t3_land", 1'b1, 8'h55, 1'b0, 2'd0);
    check("t3_slot1", 64'(data_out[15:8]), 64'h55);

    // 4: reduce to vld=0011, then remove slot 0 and insert 0x77 together
    step("t4_rm2", 1'b0, 8'h00, 1'b1, 2'd2);
    step("t4_rm3", 1'b0, 8'h00, 1'b1, 2'd3);
    check("t4_pre_vld", 64'(vld_out), 64'h3);
    step("t4_both", 1'b1, 8'h77, 1'b1, 2'd0);
    check("t4_vld", 64'(vld_out), 64'h6);
    check("t4_slot2", 64'(data_out[23:16]), 64'h77);
    check("t4_rm_data", 64'(bus.rm_data), 64'h10);

    // 5: remove an empty slot
    step("t5_err", 1'b0, 8'h00, 1'b1, 2'd3);
    check("t5_rm_err", 64'(bus.rm_err), 64'h1);
    step("t5_idle", 1'b0, 8'h00, 1'b0, 2'd0);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      step("rand", 1'($urandom_range(0, 2) != 0), 8'($urandom), 1'($urandom_range(0, 2) == 0),
           2'($urandom_range(0, 3)));
    end

    // 6: asynchronous reset between edges during an insert
    @(negedge clk);
    bus.ins_valid = 1'b1;
    bus.ins_data  = 8'hAB;
    bus.rm_req    = 1'b0;
    #2;
    resetn = 1'b0;
    #1;
    model_reset();
    check("t6_vld", 64'(vld_out), 64'h0);
    check("t6_count", 64'(count), 64'h0);
    check("t6_empty", 64'(empty), 64'h1);
    check_all("t6");
    bus.ins_valid = 1'b0;
    @(negedge clk);
    #1;
    resetn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_all("t6_release");
    step("t6_ins", 1'b1, 8'h11, 1'b0, 2'd0);
    step("t6_rm", 1'b0, 8'h00, 1'b1, 2'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
